key_switch_debouncer: RTL and testbench
=======================================

KEY_SWITCH_DEBOUNCER -- requirements
Module: key_switch_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable cycles required to accept a new level (10 ms at 50 MHz); the block SHALL support any value >= 2.
REQ-002 Parameter N_KEY, default 4, number of push-buttons.
REQ-003 Parameter N_SW, default 10, number of slide switches.
REQ-004 SI_ClkIn  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 SI_Reset_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 KEY_N  in  N_KEY  SHALL carry raw, asynchronous push-button levels (0 = pressed).
REQ-007 SW  in  N_SW  SHALL carry raw, asynchronous switch levels (1 = on).
REQ-008 evt_clear  in  N_KEY  SHALL be write-1-to-clear strobes for press_event.
REQ-009 IO_PB  out  N_KEY+1  SHALL be {1'b0, debounced pressed state}, active-high.
REQ-010 IO_Switch  out  18  SHALL be {zero-fill, debounced SW}.
REQ-011 key_pulse  out  N_KEY  SHALL carry a one-cycle pulse per accepted press.
REQ-012 press_event  out  N_KEY  SHALL hold sticky press flags.
REQ-013 evt_valid  out  1  SHALL be the OR of press_event.

Function
REQ-014 Each raw input bit SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Each bit SHALL have a private counter of width clog2(DEBOUNCE_CYCLES+1) and a stable register.
REQ-016 When the synchronized bit equals its stable value, the counter SHALL be 0 on the next edge.
REQ-017 When they differ, the counter SHALL increment each cycle.
REQ-018 When they differ and the counter equals DEBOUNCE_CYCLES-1, the next edge SHALL load the stable register with the synchronized value and zero the counter.
REQ-019 Total latency SHALL be exactly 2+DEBOUNCE_CYCLES rising edges from a raw level change held steady to the visible change on IO_PB or IO_Switch.
REQ-020 Any return of the synchronized bit to the stable value before acceptance SHALL discard the count; bounce shorter than DEBOUNCE_CYCLES SHALL never reach the outputs.
REQ-021 Counter SHALL saturate by construction and never wrap.
REQ-022 key_pulse[i] SHALL be registered and asserted for exactly the one cycle in which stable key i first reads pressed.
REQ-023 A release SHALL produce no pulse; switches SHALL produce no pulse or event.
REQ-024 press_event[i] SHALL set on the same edge key_pulse[i] asserts.
REQ-025 press_event[i] SHALL clear on the edge after evt_clear[i]=1.
REQ-026 Simultaneous set and clear of press_event[i] SHALL leave it set.
REQ-027 Bits SHALL be fully independent; simultaneous events on several bits SHALL all be reported in the same cycle.
REQ-028 IO_PB[N_KEY] and IO_Switch[17:N_SW] SHALL be constant 0.

Reset
REQ-029 While SI_Reset_N=0, all of the following SHALL be 0 asynchronously: IO_PB, IO_Switch, key_pulse, press_event, evt_valid, all counters, and stable registers (keys released, switches off).
REQ-030 Key synchronizer flops SHALL reset to 1 (released); switch synchronizer flops SHALL reset to 0.
REQ-031 Reset asserted mid-count SHALL abandon the count; after release, a held input SHALL be accepted after the full 2+DEBOUNCE_CYCLES.
REQ-032 A switch held on through reset SHALL appear on IO_Switch 2+DEBOUNCE_CYCLES edges after reset release.
REQ-033 A key held pressed through reset SHALL appear on IO_PB 2+DEBOUNCE_CYCLES edges after reset release and SHALL generate one key_pulse.

Verification (DEBOUNCE_CYCLES=8)
REQ-034 Reset pulse with KEY_N=4'hF, SW=0 -> IO_PB=0, IO_Switch=0, key_pulse=0, press_event=0, evt_valid=0 during and after reset.
REQ-035 KEY_N[0] driven 0 and held -> IO_PB[0]=1 exactly 10 edges later; key_pulse=4'b0001 for one cycle; press_event[0]=1; evt_valid=1.
REQ-036 KEY_N[1] toggled every 3 cycles for 30 cycles, then held 0 -> no output change during bounce; one key_pulse[1] 10 edges after the final transition.
REQ-037 evt_clear=4'b0001 for one cycle -> press_event[0]=0 next cycle.
REQ-038 evt_clear[2] coincident with key_pulse[2] -> press_event[2] stays 1.
REQ-039 SW[9] driven 1 -> IO_Switch[9]=1 after 10 edges; IO_Switch[17:10]=0; key_pulse stays 0.
REQ-040 SI_Reset_N pulsed low at count 5 of a pending KEY_N[3] press -> outputs 0 immediately; IO_PB[3]=1 exactly 10 edges after reset release.

Source files
------------

// File: rtl/key_switch_debouncer.sv
// Push-button and slide-switch conditioner: two-flop sync, per-bit
// stability counter, press pulses and sticky press events.
module key_switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int N_KEY           = 4,
  parameter int N_SW            = 10
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset_N,
  input  logic [N_KEY-1:0] KEY_N,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_KEY-1:0] evt_clear,
  output logic [N_KEY:0]   IO_PB,
  output logic [17:0]      IO_Switch,
  output logic [N_KEY-1:0] key_pulse,
  output logic [N_KEY-1:0] press_event,
  output logic             evt_valid
);

  localparam int NB = N_KEY + N_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB-1:0] SYNC_RST =
    {{N_SW{1'b0}}, {N_KEY{1'b1}}};

  logic [NB-1:0]    meta_q;
  logic [NB-1:0]    sync_q;
  logic [NB-1:0]    lvl;
  logic [NB-1:0]    stable_q;
  logic [NB-1:0]    stable_d;
  logic [NB-1:0]    accept;
  logic [CW-1:0]    cnt_q [NB];
  logic [CW-1:0]    cnt_d [NB];
  logic [N_KEY-1:0] pulse_q;
  logic [N_KEY-1:0] pulse_d;
  logic [N_KEY-1:0] event_q;
  logic [N_KEY-1:0] event_d;

  // Keys are inverted here so every bit is handled active-high below.
  assign lvl = {sync_q[NB-1:N_KEY], ~sync_q[N_KEY-1:0]};

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= {SW, KEY_N};
      sync_q <= meta_q;
    end
  end

  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (lvl[i] != stable_q[i]) begin
        if (cnt_q[i] == LAST) begin
          stable_d[i] = lvl[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Set wins over clear so a press coinciding with a clear is not lost.
  assign pulse_d = accept[N_KEY-1:0] & lvl[N_KEY-1:0];
  assign event_d = (event_q & ~evt_clear) | pulse_d;

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      stable_q <= '0;
      pulse_q  <= '0;
      event_q  <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      event_q  <= event_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign IO_PB       = {1'b0, stable_q[N_KEY-1:0]};
  assign IO_Switch   = 18'(stable_q[NB-1:N_KEY]);
  assign key_pulse   = pulse_q;
  assign press_event = event_q;
  assign evt_valid   = |event_q;

endmodule

// File: tb/tb_key_switch_debouncer.sv
// Directed bench for key_switch_debouncer with DEBOUNCE_CYCLES = 8.
module tb_key_switch_debouncer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [3:0]  clr;
  logic [4:0]  io_pb;
  logic [17:0] io_sw;
  logic [3:0]  pulse;
  logic [3:0]  pev;
  logic        ev_valid;

  int checks = 0;
  int errors = 0;

  key_switch_debouncer #(
    .DEBOUNCE_CYCLES(8),
    .N_KEY(4),
    .N_SW(10)
  ) dut (
    .SI_ClkIn(clk),
    .SI_Reset_N(rst_n),
    .KEY_N(key_n),
    .SW(sw),
    .evt_clear(clr),
    .IO_PB(io_pb),
    .IO_Switch(io_sw),
    .key_pulse(pulse),
    .press_event(pev),
    .evt_valid(ev_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pb"}, 32'(io_pb), 32'h0);
    chk({tag, "_sw"}, 32'(io_sw), 32'h0);
    chk({tag, "_pulse"}, 32'(pulse), 32'h0);
    chk({tag, "_event"}, 32'(pev), 32'h0);
    chk({tag, "_valid"}, 32'(ev_valid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 4'hF;
    sw    = '0;
    clr   = '0;
    step(2);
    chk_zero("in_reset");
    rst_n = 1'b1;
    step(12);
    chk_zero("after_reset");

    key_n = 4'hE;
    step(9);
    chk("k0_early_pb", 32'(io_pb), 32'h00);
    chk("k0_early_pulse", 32'(pulse), 32'h0);
    step(1);
    chk("k0_pb", 32'(io_pb), 32'h01);
    chk("k0_pulse", 32'(pulse), 32'h1);
    chk("k0_event", 32'(pev), 32'h1);
    chk("k0_valid", 32'(ev_valid), 32'h1);
    step(1);
    chk("k0_pulse_end", 32'(pulse), 32'h0);
    chk("k0_pb_hold", 32'(io_pb), 32'h01);

    for (int j = 0; j < 10; j++) begin
      key_n[1] = (j % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
      chk("bounce_pb", 32'(io_pb), 32'h01);
      chk("bounce_pulse", 32'(pulse), 32'h0);
    end
    key_n[1] = 1'b0;
    step(9);
    chk("k1_early_pb", 32'(io_pb), 32'h01);
    step(1);
    chk("k1_pb", 32'(io_pb), 32'h03);
    chk("k1_pulse", 32'(pulse), 32'h2);
    chk("k1_event", 32'(pev), 32'h3);
    step(1);
    chk("k1_pulse_end", 32'(pulse), 32'h0);

    clr = 4'b0001;
    step(1);
    clr = '0;
    chk("clr0_event", 32'(pev), 32'h2);
    chk("clr0_valid", 32'(ev_valid), 32'h1);

    key_n[2] = 1'b0;
    step(9);
    chk("k2_early_pulse", 32'(pulse), 32'h0);
    clr = 4'b0100;
    step(1);
    clr = '0;
    chk("k2_pulse", 32'(pulse), 32'h4);
    chk("k2_set_wins", 32'(pev), 32'h6);
    step(1);
    chk("k2_event_hold", 32'(pev), 32'h6);

    sw[9] = 1'b1;
    step(9);
    chk("sw9_early", 32'(io_sw), 32'h0);
    step(1);
    chk("sw9_on", 32'(io_sw), 32'h200);
    chk("sw9_no_pulse", 32'(pulse), 32'h0);
    chk("sw9_no_event", 32'(pev), 32'h6);

    key_n[3] = 1'b0;
    step(7);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    step(1);
    rst_n = 1'b1;
    step(9);
    chk("rel_early_pb", 32'(io_pb), 32'h00);
    chk("rel_early_sw", 32'(io_sw), 32'h0);
    step(1);
    chk("rel_pb", 32'(io_pb), 32'h0F);
    chk("rel_pulse", 32'(pulse), 32'hF);
    chk("rel_sw", 32'(io_sw), 32'h200);
    chk("rel_event", 32'(pev), 32'hF);
    step(1);
    chk("rel_pulse_end", 32'(pulse), 32'h0);

    key_n[0] = 1'b1;
    step(10);
    chk("k0_release_pb", 32'(io_pb), 32'h0E);
    chk("k0_release_pulse", 32'(pulse), 32'h0);
    chk("k0_release_event", 32'(pev), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
